// File: rtl/scrbrd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | scrbrd_pkg: shared types and helpers for rob_scoreboard         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package scrbrd_pkg;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_DONE  = 2'd2
  } entry_state_t;

  // Index bits plus one wrap bit.
  function automatic int scrbrd_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scrbrd_ptr.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | scrbrd_ptr: wrap-bit pointer register with increment and clear  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module scrbrd_ptr #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/rob_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rob_scoreboard: in-order alloc, out-of-order complete, in-order |
// | retire scoreboard. Optional retire counter: SCRBRD_STATS_EN.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module rob_scoreboard
  import scrbrd_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int PC_WIDTH     = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int NUM_CPL      = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_vld,
  output logic                               alloc_rdy,
  input  logic [PC_WIDTH-1:0]                alloc_pc,
  input  logic [OPCODE_WIDTH-1:0]            alloc_opcode,
  output logic [$clog2(DEPTH)-1:0]           alloc_idx,
  input  logic [NUM_CPL-1:0]                 cpl_vld,
  input  logic [NUM_CPL*$clog2(DEPTH)-1:0]   cpl_idx,
  output logic                               cpl_err,
  output logic                               ret_vld,
  input  logic                               ret_rdy,
  output logic [$clog2(DEPTH)-1:0]           ret_idx,
  output logic [PC_WIDTH-1:0]                ret_pc,
  output logic [OPCODE_WIDTH-1:0]            ret_opcode,
  input  logic                               flush,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               empty,
  output logic                               full,
  output logic [31:0]                        stat_retired
);

  localparam int IW   = $clog2(DEPTH);
  localparam int PTRW = scrbrd_ptr_w(DEPTH);

  logic [PTRW-1:0]         head_ptr;
  logic [PTRW-1:0]         tail_ptr;
  logic [IW-1:0]           head_idx;
  logic [IW-1:0]           tail_idx;
  logic                    alloc_fire;
  logic                    ret_fire;

  entry_state_t            st_q [DEPTH];
  entry_state_t            st_d [DEPTH];
  logic [PC_WIDTH-1:0]     pc_q [DEPTH];
  logic [OPCODE_WIDTH-1:0] op_q [DEPTH];
  logic                    cpl_err_q;
  logic                    cpl_err_d;

  assign head_idx = head_ptr[IW-1:0];
  assign tail_idx = tail_ptr[IW-1:0];

  assign empty     = (head_ptr == tail_ptr);
  assign full      = (head_idx == tail_idx) && (head_ptr[IW] != tail_ptr[IW]);
  assign count     = tail_ptr - head_ptr;
  assign alloc_rdy = !full;
  assign alloc_idx = tail_idx;

  // Flush wins over every other event in the same cycle.
  assign alloc_fire = alloc_vld && !full && !flush;
  assign ret_vld    = !empty && (st_q[head_idx] == ST_DONE);
  assign ret_fire   = ret_vld && ret_rdy && !flush;

  assign ret_idx    = head_idx;
  assign ret_pc     = pc_q[head_idx];
  assign ret_opcode = op_q[head_idx];
  assign cpl_err    = cpl_err_q;

  scrbrd_ptr #(.WIDTH(PTRW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ret_fire),
    .clr_i (flush),
    .ptr_o (head_ptr)
  );

  scrbrd_ptr #(.WIDTH(PTRW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc_i (alloc_fire),
    .clr_i (flush),
    .ptr_o (tail_ptr)
  );

  always_comb begin
    st_d      = st_q;
    cpl_err_d = 1'b0;
    // Completions look at the registered state, so two ports hitting the
    // same ALLOC entry both see ALLOC and neither raises an error.
    for (int p = 0; p < NUM_CPL; p++) begin
      if (cpl_vld[p]) begin
        if (st_q[cpl_idx[p*IW +: IW]] == ST_ALLOC) begin
          st_d[cpl_idx[p*IW +: IW]] = ST_DONE;
        end else begin
          cpl_err_d = 1'b1;
        end
      end
    end
    if (ret_fire) begin
      st_d[head_idx] = ST_FREE;
    end
    if (alloc_fire) begin
      st_d[tail_idx] = ST_ALLOC;
    end
    if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        st_d[e] = ST_FREE;
      end
      cpl_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        st_q[e] <= ST_FREE;
      end
      cpl_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cpl_err_q <= cpl_err_d;
    end
  end

  // Payload is only meaningful while the entry is live, so it is not reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_idx] <= alloc_pc;
      op_q[tail_idx] <= alloc_opcode;
    end
  end

`ifdef SCRBRD_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= 32'd0;
    end else if (ret_fire) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_retired = stat_q;
`else
  assign stat_retired = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_scoreboard.sv
`default_nettype none
// Testbench for rob_scoreboard (DEPTH=4): directed vector table, hand
// sequences for stats/flush/reset, then random traffic against a queue model.
module tb_rob_scoreboard;

  localparam int DEPTH = 4;

`ifdef SCRBRD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        alloc_vld;
  logic        alloc_rdy;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_opcode;
  logic [1:0]  alloc_idx;
  logic [1:0]  cpl_vld;
  logic [3:0]  cpl_idx;
  logic        cpl_err;
  logic        ret_vld;
  logic        ret_rdy;
  logic [1:0]  ret_idx;
  logic [31:0] ret_pc;
  logic [4:0]  ret_opcode;
  logic        flush;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic [31:0] stat_retired;

  rob_scoreboard #(
    .DEPTH        (DEPTH),
    .PC_WIDTH     (32),
    .OPCODE_WIDTH (5),
    .NUM_CPL      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_vld    (alloc_vld),
    .alloc_rdy    (alloc_rdy),
    .alloc_pc     (alloc_pc),
    .alloc_opcode (alloc_opcode),
    .alloc_idx    (alloc_idx),
    .cpl_vld      (cpl_vld),
    .cpl_idx      (cpl_idx),
    .cpl_err      (cpl_err),
    .ret_vld      (ret_vld),
    .ret_rdy      (ret_rdy),
    .ret_idx      (ret_idx),
    .ret_pc       (ret_pc),
    .ret_opcode   (ret_opcode),
    .flush        (flush),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .stat_retired (stat_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: live entries in program order.
  typedef struct {
    bit          done;
    int          idx;
    logic [31:0] pc;
    logic [4:0]  op;
  } ent_t;

  ent_t        q[$];
  int          m_head;
  bit          m_err;
  int unsigned m_stat;
  bit          m_valid;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    bit exp_rv;
    n = q.size();
    exp_rv = (n > 0) && q[0].done;
    chk("count", {29'd0, count}, n);
    chk("empty", {31'd0, empty}, {31'd0, n == 0});
    chk("full", {31'd0, full}, {31'd0, n == DEPTH});
    chk("alloc_rdy", {31'd0, alloc_rdy}, {31'd0, n < DEPTH});
    chk("alloc_idx", {30'd0, alloc_idx}, (m_head + n) % DEPTH);
    chk("ret_vld", {31'd0, ret_vld}, {31'd0, exp_rv});
    if (exp_rv) begin
      chk("ret_idx", {30'd0, ret_idx}, q[0].idx);
      chk("ret_pc", ret_pc, q[0].pc);
      chk("ret_opcode", {27'd0, ret_opcode}, {27'd0, q[0].op});
    end
    chk("cpl_err", {31'd0, cpl_err}, {31'd0, m_err});
    chk("stat_retired", stat_retired, STATS ? m_stat : 32'd0);
  endtask

  task automatic model_update(input logic r, input logic fl, input logic av,
                              input logic [31:0] pc, input logic [4:0] op,
                              input logic [1:0] cv, input logic [3:0] ci,
                              input logic rr);
    ent_t pre[$];
    ent_t e;
    int   n;
    int   head_pre;
    int   idx;
    bit   hit;
    bit   rf;
    if (r) begin
      q.delete();
      m_head = 0;
      m_err  = 1'b0;
      m_stat = 0;
      return;
    end
    if (fl) begin
      q.delete();
      m_head = 0;
      m_err  = 1'b0;
      return;
    end
    pre      = q;
    n        = pre.size();
    head_pre = m_head;
    m_err    = 1'b0;
    rf       = (n > 0) && pre[0].done && rr;
    for (int p = 0; p < 2; p++) begin
      if (cv[p]) begin
        idx = int'(ci[p*2 +: 2]);
        hit = 1'b0;
        for (int k = 0; k < n; k++) begin
          if (pre[k].idx == idx && !pre[k].done) begin
            e = q[k];
            e.done = 1'b1;
            q[k] = e;
            hit = 1'b1;
          end
        end
        if (!hit) m_err = 1'b1;
      end
    end
    if (rf) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
      m_stat++;
    end
    if (av && n < DEPTH) begin
      e.done = 1'b0;
      e.idx  = (head_pre + n) % DEPTH;
      e.pc   = pc;
      e.op   = op;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic fl, input logic av,
                      input logic [31:0] pc, input logic [4:0] op,
                      input logic [1:0] cv, input logic [3:0] ci, input logic rr);
    rst          = r;
    flush        = fl;
    alloc_vld    = av;
    alloc_pc     = pc;
    alloc_opcode = op;
    cpl_vld      = cv;
    cpl_idx      = ci;
    ret_rdy      = rr;
    #1;
    if (m_valid) check_model();
    model_update(r, fl, av, pc, op, cv, ci, rr);
    if (r) m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        av;
    logic [31:0] pc;
    logic [1:0]  cv;
    logic [3:0]  ci;
    logic        rr;
    logic        fl;
    int          e_cnt;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_err;
    logic        e_full;
    int          e_aidx;
  } vec_t;

  vec_t vt[18];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_valid = 1'b0;
    m_head  = 0;
    m_err   = 1'b0;
    m_stat  = 0;

    // Expected outputs are the values seen after the vector's clock edge.
    vt[0]  = '{1'b1, 32'h100, 2'b00, 4'h0, 1'b0, 1'b0, 1, 1'b0, 32'h0,   1'b0, 1'b0, 1};
    vt[1]  = '{1'b1, 32'h104, 2'b00, 4'h0, 1'b0, 1'b0, 2, 1'b0, 32'h0,   1'b0, 1'b0, 2};
    vt[2]  = '{1'b1, 32'h108, 2'b00, 4'h0, 1'b0, 1'b0, 3, 1'b0, 32'h0,   1'b0, 1'b0, 3};
    vt[3]  = '{1'b0, 32'h0,   2'b01, 4'h2, 1'b1, 1'b0, 3, 1'b0, 32'h0,   1'b0, 1'b0, 3};
    vt[4]  = '{1'b0, 32'h0,   2'b10, 4'h0, 1'b1, 1'b0, 3, 1'b1, 32'h100, 1'b0, 1'b0, 3};
    vt[5]  = '{1'b0, 32'h0,   2'b00, 4'h0, 1'b1, 1'b0, 2, 1'b0, 32'h0,   1'b0, 1'b0, 3};
    vt[6]  = '{1'b0, 32'h0,   2'b00, 4'h0, 1'b1, 1'b0, 2, 1'b0, 32'h0,   1'b0, 1'b0, 3};
    vt[7]  = '{1'b0, 32'h0,   2'b11, 4'h5, 1'b1, 1'b0, 2, 1'b1, 32'h104, 1'b0, 1'b0, 3};
    vt[8]  = '{1'b0, 32'h0,   2'b01, 4'h1, 1'b1, 1'b0, 1, 1'b1, 32'h108, 1'b1, 1'b0, 3};
    vt[9]  = '{1'b1, 32'h10C, 2'b00, 4'h0, 1'b0, 1'b0, 2, 1'b1, 32'h108, 1'b0, 1'b0, 0};
    vt[10] = '{1'b1, 32'h110, 2'b00, 4'h0, 1'b0, 1'b0, 3, 1'b1, 32'h108, 1'b0, 1'b0, 1};
    vt[11] = '{1'b1, 32'h114, 2'b00, 4'h0, 1'b0, 1'b0, 4, 1'b1, 32'h108, 1'b0, 1'b1, 2};
    vt[12] = '{1'b1, 32'h118, 2'b01, 4'h3, 1'b0, 1'b0, 4, 1'b1, 32'h108, 1'b0, 1'b1, 2};
    vt[13] = '{1'b1, 32'h11C, 2'b00, 4'h0, 1'b1, 1'b0, 3, 1'b1, 32'h10C, 1'b0, 1'b0, 2};
    vt[14] = '{1'b1, 32'h120, 2'b00, 4'h0, 1'b1, 1'b0, 3, 1'b0, 32'h0,   1'b0, 1'b0, 3};
    vt[15] = '{1'b1, 32'h124, 2'b01, 4'h0, 1'b1, 1'b1, 0, 1'b0, 32'h0,   1'b0, 1'b0, 0};
    vt[16] = '{1'b0, 32'h0,   2'b01, 4'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0,   1'b1, 1'b0, 0};
    vt[17] = '{1'b0, 32'h0,   2'b00, 4'h0, 1'b0, 1'b0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 0};

    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_alloc_rdy", {31'd0, alloc_rdy}, 32'd1);

    for (int k = 0; k < 18; k++) begin
      step(1'b0, vt[k].fl, vt[k].av, vt[k].pc, 5'(k), vt[k].cv, vt[k].ci, vt[k].rr);
      chk($sformatf("vec%0d_count", k), {29'd0, count}, vt[k].e_cnt);
      chk($sformatf("vec%0d_empty", k), {31'd0, empty}, {31'd0, vt[k].e_cnt == 0});
      chk($sformatf("vec%0d_full", k), {31'd0, full}, {31'd0, vt[k].e_full});
      chk($sformatf("vec%0d_alloc_rdy", k), {31'd0, alloc_rdy}, {31'd0, !vt[k].e_full});
      chk($sformatf("vec%0d_ret_vld", k), {31'd0, ret_vld}, {31'd0, vt[k].e_rv});
      if (vt[k].e_rv) chk($sformatf("vec%0d_ret_pc", k), ret_pc, vt[k].e_pc);
      chk($sformatf("vec%0d_cpl_err", k), {31'd0, cpl_err}, {31'd0, vt[k].e_err});
      chk($sformatf("vec%0d_alloc_idx", k), {30'd0, alloc_idx}, vt[k].e_aidx);
    end

    // Five retires, flush keeps the counter, reset clears it.
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4*k), 5'(k), 2'b00, 4'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 2'b01, {2'b00, 2'(k % DEPTH)}, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);
    chk("stat_after_flush", stat_retired, STATS ? 32'd5 : 32'd0);
    chk("count_after_flush", {29'd0, count}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);
    chk("stat_after_rst", stat_retired, 32'd0);

    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 49) == 0,
           1'($urandom_range(0, 1)),
           $urandom,
           5'($urandom),
           2'($urandom),
           4'($urandom),
           $urandom_range(0, 9) < 7);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 2'b00, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
